imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: BITS, default 8, data word width.
REQ-002 Parameter: MEMORY_BITS, default 8, write-address width.
REQ-003 Parameter: MEMORY_SIZE, default 256, number of memory words.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle request to begin a load.
REQ-007 Port: in_valid  input  1  in_data holds a byte.
REQ-008 Port: in_data  input  BITS  incoming stream byte.
REQ-009 Port: in_ready  output  1  loader accepts in_data this cycle.
REQ-010 Port: we  output  1  instruction-memory write enable.
REQ-011 Port: waddr  output  MEMORY_BITS  write address.
REQ-012 Port: wdata  output  BITS  write data.
REQ-013 Port: cpu_hold  output  1  holds CPU/PC in reset while loading.
REQ-014 Port: done  output  1  image loaded and checksum matched.
REQ-015 Port: error  output  1  checksum mismatch on last load.

Function
REQ-016 The loader SHALL count a byte as accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-017 The loader SHALL implement states IDLE, LEN, DATA, CHECK, DONE, ERR.
REQ-018 In IDLE, DONE or ERR, start=1 SHALL move the FSM to LEN, clear done/error, zero the address counter and zero the checksum, all on the next edge.
REQ-019 start SHALL be ignored in LEN, DATA and CHECK.
REQ-020 in_ready SHALL be 1 exactly in LEN, DATA and CHECK, and 0 otherwise.
REQ-021 In LEN, the accepted byte L SHALL set the word count to L+1 (1..256), and the FSM SHALL move to DATA.
REQ-022 In DATA, each accepted byte SHALL be written: we=1, waddr=counter, wdata=byte, all registered one cycle after acceptance.
REQ-023 In DATA, each accepted byte SHALL also be XORed into the running checksum and SHALL increment the address counter modulo 2^MEMORY_BITS.
REQ-024 After the (L+1)th data byte is accepted, the FSM SHALL move to CHECK; L=255 SHALL write addresses 0..255, and the counter SHALL wrap to 0 without extra writes.
REQ-025 we SHALL be 0 on every cycle not following a DATA acceptance; waddr and wdata SHALL hold their last values while we=0.
REQ-026 In CHECK, the accepted byte SHALL be compared with the checksum: equal -> DONE, done=1; unequal -> ERR, error=1.
REQ-027 cpu_hold SHALL be 1 in LEN, DATA, CHECK and ERR, and 0 in IDLE and DONE.
REQ-028 done and error SHALL be registered levels held until the next accepted start or reset, and SHALL never be 1 simultaneously.
REQ-029 in_valid=0 gaps of any length SHALL stall the FSM with no state, counter or write change.

Reset
REQ-030 reset=1 on an edge SHALL force IDLE, counter=0, checksum=0, we=0, waddr=0, wdata=0, done=0, error=0, cpu_hold=0, in_ready=0.
REQ-031 reset SHALL take priority over start and any handshake in the same cycle.
REQ-032 reset during LEN, DATA or CHECK SHALL abort the load with no further writes; words already written are not undone.

Structure
REQ-033 BITS, MEMORY_BITS, MEMORY_SIZE defaults and the FSM state encoding SHALL live in the shared utils header/package used by instruction_memory.
REQ-034 The design SHALL be a single module with no sub-modules; the bench SHALL instantiate imem_loader driving instruction_memory's write side and read back through pc/instruction.

Verification
REQ-035 Scenario: start, then stream 0x03, 0x11, 0x22, 0x33, 0x44, 0x44 -> writes 0x11..0x44 at addresses 0..3, done=1, cpu_hold=0, error=0.
REQ-036 Scenario: same stream with checksum byte 0x45 -> error=1, done=0, cpu_hold stays 1, and exactly 4 writes occur.
REQ-037 Scenario: L=0xFF, data=address value 0x00..0xFF, checksum 0x00 -> 256 writes; instruction readback at pc 0..255 equals pc; done=1.
REQ-038 Scenario: in_valid toggling 1/0 every cycle during DATA -> identical memory contents; we is asserted only on the cycle after each acceptance.
REQ-039 Scenario: reset asserted after the 2nd data byte of a 4-word load -> exactly 2 writes, IDLE, all outputs 0; a following full load succeeds.
REQ-040 Scenario: start pulsed during DATA and together with reset -> both ignored; load unaffected or reset wins, respectively.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared widths and FSM encoding for the loader and instruction memory
package imem_loader_pkg;

  localparam int DEF_BITS        = 8;
  localparam int DEF_MEMORY_BITS = 8;
  localparam int DEF_MEMORY_SIZE = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  function automatic logic is_loading(state_t s);
    return (s == LEN) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and memory write port of the loader
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int BITS        = DEF_BITS,
  parameter int MEMORY_BITS = DEF_MEMORY_BITS
);

  logic                   in_valid;
  logic [BITS-1:0]        in_data;
  logic                   in_ready;
  logic                   we;
  logic [MEMORY_BITS-1:0] waddr;
  logic [BITS-1:0]        wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

endinterface

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - instruction store with a write port and asynchronous read by pc
module instruction_memory
  import imem_loader_pkg::*;
#(
  parameter int BITS        = DEF_BITS,
  parameter int MEMORY_BITS = DEF_MEMORY_BITS,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [MEMORY_BITS-1:0] waddr,
  input  logic [BITS-1:0]        wdata,
  input  logic [MEMORY_BITS-1:0] pc,
  output logic [BITS-1:0]        instruction
);

  logic [BITS-1:0] mem [MEMORY_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign instruction = mem[pc];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed, XOR-checksummed image into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int BITS        = DEF_BITS,
  parameter int MEMORY_BITS = DEF_MEMORY_BITS,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.master bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  if (MEMORY_SIZE > (1 << MEMORY_BITS)) begin : g_size_check
    $error("MEMORY_SIZE exceeds the write address space");
  end

  state_t                 state_q, state_d;
  logic [MEMORY_BITS-1:0] addr_q;
  logic [BITS-1:0]        checksum_q;
  logic [BITS:0]          remaining_q;  // one wider than a byte so L=255 gives 256 words
  logic                   accept;

  assign bus.in_ready = is_loading(state_q);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cpu_hold     = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN;
      LEN:             if (accept) state_d = DATA;
      DATA:            if (accept && remaining_q == (BITS+1)'(1)) state_d = CHECK;
      CHECK:           if (accept) state_d = (bus.in_data == checksum_q) ? DONE : ERR;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      checksum_q  <= '0;
      remaining_q <= '0;
      bus.we      <= 1'b0;
      bus.waddr   <= '0;
      bus.wdata   <= '0;
    end else begin
      bus.we <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            addr_q     <= '0;
            checksum_q <= '0;
          end
        end
        LEN: begin
          if (accept) remaining_q <= {1'b0, bus.in_data} + (BITS+1)'(1);
        end
        DATA: begin
          if (accept) begin
            bus.we      <= 1'b1;
            bus.waddr   <= addr_q;
            bus.wdata   <= bus.in_data;
            checksum_q  <= checksum_q ^ bus.in_data;
            addr_q      <= addr_q + MEMORY_BITS'(1);
            remaining_q <= remaining_q - (BITS+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table, hand-written and random load sequences for imem_loader
module tb_imem_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [7:0] pc;
  logic [7:0] instruction;

  int checks = 0;
  int fails  = 0;
  logic mon_en = 1'b0;
  logic data_phase = 1'b0;
  logic [15:0] wlog[$];
  logic [7:0] pay[256];

  typedef struct {
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] cks_delta;
    int         gap_mode;
    logic       exp_done;
    int         exp_writes;
  } vec_t;

  vec_t vecs[6];

  imem_loader_if #(.BITS(8), .MEMORY_BITS(8)) bus ();

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  instruction_memory imem (
    .clk         (clk),
    .we          (bus.we),
    .waddr       (bus.waddr),
    .wdata       (bus.wdata),
    .pc          (pc),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: we must be high exactly after a DATA-phase handshake.
  task automatic tick();
    logic exp_we;
    exp_we = !reset && bus.in_valid && bus.in_ready && data_phase;
    @(posedge clk);
    #1;
    if (mon_en) chk("we_timing", bus.we, exp_we);
    if (bus.we) wlog.push_back({bus.waddr, bus.wdata});
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_we"}, bus.we, 0);
    chk({tag, "_waddr"}, bus.waddr, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int gap_len(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic is_data, input int gap);
    int n;
    data_phase  = is_data;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.in_data = 8'($urandom);
      tick();
    end
  endtask

  task automatic run_load(input int len, input logic [7:0] cks, input int gap_mode,
                          input logic exp_done, input int exp_writes);
    wlog.delete();
    do_start();
    chk("busy_hold", cpu_hold, 1);
    chk("busy_ready", bus.in_ready, 1);
    chk("busy_done", done, 0);
    chk("busy_error", error, 0);
    send_byte(len[7:0], 1'b0, gap_len(gap_mode));
    for (int i = 0; i <= len; i++) send_byte(pay[i], 1'b1, gap_len(gap_mode));
    send_byte(cks, 1'b0, gap_len(gap_mode));
    chk("end_done", done, exp_done);
    chk("end_error", error, !exp_done);
    chk("end_hold", cpu_hold, !exp_done);
    chk("end_ready", bus.in_ready, 0);
    chk("write_count", wlog.size(), exp_writes);
    for (int i = 0; i < wlog.size() && i <= len; i++) chk("write_rec", wlog[i], {i[7:0], pay[i]});
    for (int i = 0; i <= len; i++) begin
      pc = i[7:0];
      tick();
      chk("readback", instruction, pay[i]);
    end
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] cks;
    int len;

    vecs[0] = '{len: 3,   base: 8'h11, step: 8'h11, cks_delta: 8'h00, gap_mode: 0, exp_done: 1'b1, exp_writes: 4};
    vecs[1] = '{len: 3,   base: 8'h11, step: 8'h11, cks_delta: 8'h01, gap_mode: 0, exp_done: 1'b0, exp_writes: 4};
    vecs[2] = '{len: 255, base: 8'h00, step: 8'h01, cks_delta: 8'h00, gap_mode: 0, exp_done: 1'b1, exp_writes: 256};
    vecs[3] = '{len: 3,   base: 8'h11, step: 8'h11, cks_delta: 8'h00, gap_mode: 1, exp_done: 1'b1, exp_writes: 4};
    vecs[4] = '{len: 0,   base: 8'hA5, step: 8'h00, cks_delta: 8'h00, gap_mode: 2, exp_done: 1'b1, exp_writes: 1};
    vecs[5] = '{len: 0,   base: 8'h5A, step: 8'h00, cks_delta: 8'hFF, gap_mode: 2, exp_done: 1'b0, exp_writes: 1};

    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    pc = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");
    mon_en = 1'b1;

    foreach (vecs[v]) begin
      x = 8'h00;
      for (int i = 0; i <= vecs[v].len; i++) begin
        pay[i] = vecs[v].base + 8'(vecs[v].step * i);
        x ^= pay[i];
      end
      run_load(vecs[v].len, x ^ vecs[v].cks_delta, vecs[v].gap_mode,
               vecs[v].exp_done, vecs[v].exp_writes);
    end

    // Abort after the second data byte of a four-word load.
    wlog.delete();
    do_start();
    send_byte(8'd3, 1'b0, 0);
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'hBB, 1'b1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_writes", wlog.size(), 2);
    check_idle("abort");
    tick();
    chk("abort_no_more_writes", wlog.size(), 2);
    for (int i = 0; i < 4; i++) pay[i] = 8'hC0 + 8'(i);
    run_load(3, 8'h00, 0, 1'b1, 4);

    // start during DATA is ignored.
    wlog.delete();
    do_start();
    send_byte(8'd3, 1'b0, 0);
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_start_hold", cpu_hold, 1);
    chk("mid_start_ready", bus.in_ready, 1);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 0);
    send_byte(8'h44, 1'b0, 0);
    chk("mid_start_done", done, 1);
    chk("mid_start_writes", wlog.size(), 4);
    if (wlog.size() == 4) chk("mid_start_addr2", wlog[2], 16'h0233);

    // start together with reset: reset wins.
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check_idle("start_reset");

    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(0, 40));
      x = 8'h00;
      for (int i = 0; i <= len; i++) begin
        pay[i] = 8'($urandom);
        x ^= pay[i];
      end
      cks = ($urandom_range(0, 1) == 1) ? x : x ^ 8'($urandom_range(1, 255));
      run_load(len, cks, 2, cks == x, len + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
